// File: rtl/pll_lock_sequencer.sv
// PLL power-up sequencer for the iCE40 SB_PLL40_CORE wrapper.
// It holds the PLL in reset and waits for LOCK with a timeout. LOCK must
// stay high for a set time before READY is raised. The sequencer retries
// on a timeout or on loss of lock. When the retries run out it parks in
// FAULT and, optionally, bypasses the PLL.
module pll_lock_sequencer #(
  parameter int RESET_CYCLES    = 100,
  parameter int LOCK_TIMEOUT    = 10000,
  parameter int STABLE_CYCLES   = 1000,
  parameter int MAX_RETRIES     = 3,
  parameter int BYPASS_ON_FAULT = 1,
  localparam int RW             = $clog2(MAX_RETRIES + 1)
) (
  input  logic          REFERENCECLK,
  input  logic          RESET,
  input  logic          PLL_LOCK,
  input  logic          RESTART,
  output logic          PLL_RESETB,
  output logic          PLL_BYPASS,
  output logic          READY,
  output logic          FAULT,
  output logic [RW-1:0] RETRY_COUNT
);

  // One counter serves every timed state, so size it for the longest interval.
  localparam int CNT_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RETRY_ONE    = RW'(1);
  localparam logic          BYPASS_LVL   = (BYPASS_ON_FAULT != 0);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FLT       = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lock_meta;
  logic          lock_s;
  logic          attempt_fail;

  // Two-flop synchronizer that brings the asynchronous LOCK into REFERENCECLK.
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= PLL_LOCK;
      lock_s    <= lock_meta;
    end
  end

  // An attempt fails on a WAIT_LOCK timeout, or on lock loss after READY.
  // A lock that arrives on the timeout cycle takes precedence over the timeout.
  always_comb begin
    attempt_fail = 1'b0;
    if (state == WAIT_LOCK && !lock_s && cnt == TIMEOUT_LAST) attempt_fail = 1'b1;
    if (state == RUN && !lock_s)                               attempt_fail = 1'b1;
  end

  // Sequencer FSM. Every output is a flop that is updated on the same edge
  // as the state change it belongs to.
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state       <= HOLD;
      cnt         <= '0;
      PLL_RESETB  <= 1'b0;
      PLL_BYPASS  <= 1'b0;
      READY       <= 1'b0;
      FAULT       <= 1'b0;
      RETRY_COUNT <= '0;
    end else if (RESTART) begin
      state       <= HOLD;
      cnt         <= '0;
      PLL_RESETB  <= 1'b0;
      PLL_BYPASS  <= 1'b0;
      READY       <= 1'b0;
      FAULT       <= 1'b0;
      RETRY_COUNT <= '0;
    end else if (attempt_fail) begin
      cnt        <= '0;
      PLL_RESETB <= 1'b0;
      READY      <= 1'b0;
      if (RETRY_COUNT == RETRY_LAST) begin
        RETRY_COUNT <= RETRY_MAX;
        state       <= FLT;
        FAULT       <= 1'b1;
        PLL_BYPASS  <= BYPASS_LVL;
      end else begin
        RETRY_COUNT <= RETRY_COUNT + RETRY_ONE;
        state       <= HOLD;
      end
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            PLL_RESETB <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE: begin
          // A glitch restarts the lock wait. It is not counted as a failure.
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= RUN;
            cnt   <= '0;
            READY <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RUN: begin
          cnt <= '0;
        end
        FLT: begin
          cnt <= '0;
        end
        default: begin
          state <= HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer. A timestamp-based phase model
// predicts the outputs after every clock edge. A separate monitor compares
// these predictions against the DUT on the falling edge.
module tb_pll_lock_sequencer;

  localparam int RC  = 4;
  localparam int TO  = 16;
  localparam int SC  = 8;
  localparam int MR  = 2;
  localparam int BOF = 1;

  logic       REFERENCECLK = 1'b0;
  logic       RESET        = 1'b0;
  logic       PLL_LOCK     = 1'b0;
  logic       RESTART      = 1'b0;
  logic       PLL_RESETB;
  logic       PLL_BYPASS;
  logic       READY;
  logic       FAULT;
  logic [1:0] RETRY_COUNT;

  pll_lock_sequencer #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC),
    .MAX_RETRIES(MR), .BYPASS_ON_FAULT(BOF)
  ) dut (
    .REFERENCECLK(REFERENCECLK), .RESET(RESET), .PLL_LOCK(PLL_LOCK),
    .RESTART(RESTART), .PLL_RESETB(PLL_RESETB), .PLL_BYPASS(PLL_BYPASS),
    .READY(READY), .FAULT(FAULT), .RETRY_COUNT(RETRY_COUNT)
  );

  always #5 REFERENCECLK = ~REFERENCECLK;

  typedef struct packed {
    logic       resetb;
    logic       bypass;
    logic       ready;
    logic       fault;
    logic [1:0] retry;
  } obs_t;

  obs_t sb[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Reference model phases: which part of the bring-up sequence we are in.
  localparam int PH_HOLD   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAULT  = 4;

  // Behavioural model. Each phase has a start edge. The elapsed edge count
  // decides the timed transitions. The LOCK value seen by the sequencer is
  // the one sampled two edges earlier.
  initial begin
    int   k;
    int   phase;
    int   start;
    int   retries;
    bit   seen;
    bit   lk_hist[$];
    obs_t e;
    k = 0; phase = PH_HOLD; start = 0; retries = 0;
    forever begin
      @(posedge REFERENCECLK);
      k++;
      if (!RESET) begin
        phase = PH_HOLD; start = k; retries = 0;
        lk_hist.delete();
      end else begin
        seen = (lk_hist.size() >= 2) ? lk_hist[lk_hist.size() - 2] : 1'b0;
        lk_hist.push_back(PLL_LOCK);
        if (lk_hist.size() > 3) void'(lk_hist.pop_front());
        if (RESTART) begin
          phase = PH_HOLD; start = k; retries = 0;
        end else begin
          bit failed;
          failed = 1'b0;
          case (phase)
            PH_HOLD:   if (k - start == RC) begin phase = PH_WAIT; start = k; end
            PH_WAIT: begin
              if (seen) begin phase = PH_STABLE; start = k; end
              else if (k - start == TO) failed = 1'b1;
            end
            PH_STABLE: begin
              if (!seen) begin phase = PH_WAIT; start = k; end
              else if (k - start == SC) begin phase = PH_RUN; start = k; end
            end
            PH_RUN:    if (!seen) failed = 1'b1;
            default: ;
          endcase
          if (failed) begin
            retries++;
            phase = (retries >= MR) ? PH_FAULT : PH_HOLD;
            start = k;
          end
        end
      end
      e.resetb = (phase == PH_WAIT || phase == PH_STABLE || phase == PH_RUN);
      e.ready  = (phase == PH_RUN);
      e.fault  = (phase == PH_FAULT);
      e.bypass = (phase == PH_FAULT) && (BOF != 0);
      e.retry  = 2'(retries);
      sb.push_back(e);
    end
  end

  // Monitor: compare each prediction with the DUT outputs away from the active edge.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge REFERENCECLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{PLL_RESETB, PLL_BYPASS, READY, FAULT, RETRY_COUNT};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got resetb=%b bypass=%b ready=%b fault=%b retry=%0d, want resetb=%b bypass=%b ready=%b fault=%b retry=%0d",
                   $time, a.resetb, a.bypass, a.ready, a.fault, a.retry,
                   e.resetb, e.bypass, e.ready, e.fault, e.retry);
        end
      end
    end
  end

  task automatic step(input logic lk, input logic rs);
    @(negedge REFERENCECLK);
    PLL_LOCK = lk;
    RESTART  = rs;
  endtask

  task automatic hold_lock(input logic lk, input int n);
    for (int i = 0; i < n; i++) step(lk, 1'b0);
  endtask

  // Drop RESET between edges. The outputs must clear before any clock edge.
  task automatic async_reset_pulse();
    obs_t a;
    @(negedge REFERENCECLK);
    RESTART = 1'b0;
    #2 RESET = 1'b0;
    #1;
    a = '{PLL_RESETB, PLL_BYPASS, READY, FAULT, RETRY_COUNT};
    vectors++;
    if (a !== obs_t'(6'b0)) begin
      miscompares++;
      $display("FAIL async_reset t=%0t got %b want %b", $time, a, 6'b0);
    end
    @(negedge REFERENCECLK);
    @(negedge REFERENCECLK);
    RESET = 1'b1;
  endtask

  initial begin
    int lvl;
    int len;
    int cyc;
    RESET = 1'b0; PLL_LOCK = 1'b0; RESTART = 1'b0;
    repeat (3) @(negedge REFERENCECLK);
    RESET = 1'b1;

    // Nominal lock, then a lock loss in RUN followed by a relock.
    hold_lock(1'b0, RC + 5);
    hold_lock(1'b1, 20);
    hold_lock(1'b0, 3);
    hold_lock(1'b1, 30);

    // Glitchy lock after a RESTART issued while in RUN.
    step(1'b0, 1'b1);
    hold_lock(1'b0, 8);
    hold_lock(1'b1, 5);
    hold_lock(1'b0, 1);
    hold_lock(1'b1, 25);

    // Timeouts until FAULT, dwell in FAULT, then a RESTART.
    hold_lock(1'b0, 70);
    step(1'b0, 1'b1);
    hold_lock(1'b0, RC + 8);

    // Async reset in the middle of WAIT_LOCK, then the normal sequence again.
    async_reset_pulse();
    hold_lock(1'b1, 9);
    step(1'b1, 1'b1);
    hold_lock(1'b1, 30);

    // Randomized lock waveforms with occasional RESTART and RESET pulses.
    cyc = 0;
    while (cyc < 2000) begin
      lvl = $urandom_range(0, 1);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 70) : $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        step(lvl[0], ($urandom_range(0, 149) == 0));
        cyc++;
      end
      if ($urandom_range(0, 40) == 0) begin
        async_reset_pulse();
        cyc += 2;
      end
    end

    step(1'b0, 1'b0);
    repeat (2) @(negedge REFERENCECLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
